maggie_slot_sequencer: RTL

MAGGIE_SLOT_SEQUENCER -- requirements
Module: maggie_slot_sequencer

---
 rtl/maggie_seq_pkg.sv | 26 ++
 rtl/maggie_tag_pipe.sv | 32 +++
 rtl/maggie_slot_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/maggie_seq_pkg.sv
// Shared types and constants for the MAGGIE slot sequencer: slot count,
// bus widths, the host FSM state encoding and the in-flight read tag.
package maggie_seq_pkg;

    localparam int SLOTS       = 16;
    localparam int PC_W        = 4;
    localparam int ADDR_W      = 20;
    localparam int DATA_W      = 16;
    localparam int LAYER_IDX_W = 3;

    typedef enum logic [1:0] {
        HOST_IDLE,
        HOST_WAIT,
        HOST_ACK,
        HOST_HOLD
    } host_state_e;

    typedef struct packed {
        logic                   valid;
        logic                   is_host;
        logic [LAYER_IDX_W-1:0] layer;
    } tag_t;

    localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/maggie_tag_pipe.sv
// Fixed-latency shift pipeline carrying the owner tag of each RAM access so
// the returning ram_din word can be steered to the right consumer.
module maggie_tag_pipe
    import maggie_seq_pkg::*;
#(
    parameter int RAM_READ_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [RAM_READ_CYCLES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_READ_CYCLES; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < RAM_READ_CYCLES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Tag enters alongside ram_rd, so the last stage lines up with valid ram_din.
    assign tag_o = stage_q[RAM_READ_CYCLES-1];

endmodule

// File: rtl/maggie_slot_sequencer.sv
// Time-slot arbiter for the shared MAGGIE RAM read port: slots 0..LAYERS-1 serve
// the address generators, the rest serve an optional host port (MAGGIE_HOST_PORT_EN).
module maggie_slot_sequencer
    import maggie_seq_pkg::*;
#(
    parameter int LAYERS          = 4,
    parameter int RAM_READ_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LAYERS*ADDR_W-1:0] layer_addr,
    input  logic [DATA_W-1:0]        ram_din,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDR_W-1:0]        host_addr,
    input  logic [DATA_W-1:0]        host_wdata,
    output logic [PC_W-1:0]          pc_ena,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic [LAYERS*DATA_W-1:0] layer_dout,
    output logic                     host_ack,
    output logic [DATA_W-1:0]        host_rdata
);

    localparam logic [PC_W-1:0] FIRST_HOST_SLOT = PC_W'(LAYERS);
    localparam logic [PC_W-1:0] LAST_SLOT       = PC_W'(SLOTS - 1);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_rd_q, ram_rd_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              layer_slot;
    logic              wrap;
    logic              host_start;
    tag_t              issue_tag;
    tag_t              exit_tag;

    assign pc_d       = pc_q + PC_W'(1);
    assign layer_slot = (pc_q < FIRST_HOST_SLOT);
    assign wrap       = (pc_q == LAST_SLOT);

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < LAYERS; k++) begin
            if (pc_q == PC_W'(k)) begin
                sel_addr = layer_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // Issue stage: whatever is decided in slot k appears on the RAM port in slot k+1.
    always_comb begin
        ram_addr_d        = ram_addr_q;
        ram_wdata_d       = ram_wdata_q;
        ram_rd_d          = 1'b0;
        ram_wr_d          = 1'b0;
        issue_tag         = TAG_NONE;
        if (layer_slot) begin
            ram_addr_d        = sel_addr;
            ram_rd_d          = 1'b1;
            issue_tag.valid   = 1'b1;
            issue_tag.is_host = 1'b0;
            issue_tag.layer   = pc_q[LAYER_IDX_W-1:0];
        end else if (host_start) begin
            ram_addr_d        = host_addr;
            ram_rd_d          = !host_we;
            ram_wr_d          = host_we;
            issue_tag.valid   = 1'b1;
            issue_tag.is_host = 1'b1;
            if (host_we) begin
                ram_wdata_d = host_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
        end
    end

    maggie_tag_pipe #(
        .RAM_READ_CYCLES(RAM_READ_CYCLES)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (issue_tag),
        .tag_o (exit_tag)
    );

    // Staging keeps a frame's words private until the wrap publishes them together.
    for (genvar gi = 0; gi < LAYERS; gi++) begin : g_lane
        logic [DATA_W-1:0] staging_q, staging_d;
        logic [DATA_W-1:0] dout_q, dout_d;

        always_comb begin
            staging_d = staging_q;
            dout_d    = dout_q;
            if (exit_tag.valid && !exit_tag.is_host &&
                (exit_tag.layer == LAYER_IDX_W'(gi))) begin
                staging_d = ram_din;
            end
            if (wrap) begin
                dout_d = staging_q;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                staging_q <= '0;
                dout_q    <= '0;
            end else begin
                staging_q <= staging_d;
                dout_q    <= dout_d;
            end
        end

        assign layer_dout[gi*DATA_W +: DATA_W] = dout_q;
    end

`ifdef MAGGIE_HOST_PORT_EN
    host_state_e       host_state_q, host_state_d;
    logic              host_we_q, host_we_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    assign host_start = (host_state_q == HOST_IDLE) && host_req && !layer_slot;

    always_comb begin
        host_state_d = host_state_q;
        host_we_d    = host_we_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        case (host_state_q)
            HOST_IDLE: begin
                if (host_start) begin
                    host_state_d = HOST_WAIT;
                    host_we_d    = host_we;
                end
            end
            HOST_WAIT: begin
                if (exit_tag.valid && exit_tag.is_host) begin
                    host_state_d = HOST_ACK;
                    host_ack_d   = 1'b1;
                    if (!host_we_q) begin
                        host_rdata_d = ram_din;
                    end
                end
            end
            HOST_ACK:  host_state_d = HOST_HOLD;
            // Wait for the request to drop so a held level is served only once.
            HOST_HOLD: begin
                if (!host_req) begin
                    host_state_d = HOST_IDLE;
                end
            end
            default:   host_state_d = HOST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_state_q <= HOST_IDLE;
            host_we_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_state_q <= host_state_d;
            host_we_q    <= host_we_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
`else
    logic unused_host;

    assign unused_host = ^{host_req, host_we, host_addr, host_wdata};
    assign host_start  = 1'b0;
    assign host_ack    = 1'b0;
    assign host_rdata  = '0;
`endif

    assign pc_ena    = pc_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_rd    = ram_rd_q;
    assign ram_wr    = ram_wr_q;

endmodule
